// File: rtl/dcache_pkg.sv
// Shared geometry constants and FSM encoding for the direct-mapped data cache.
package dcache_pkg;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int LINES    = 8;
  localparam int BLOCK_W  = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: data/tag arrays plus valid/dirty bits, read combinationally by index.
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                byte_we,
  input  logic [7:0]          byte_data,
  input  logic                fill_we,
  input  logic [BLOCK_W-1:0]  fill_data,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic                clean_we,
  output logic [BLOCK_W-1:0]  line_data,
  output logic [TAG_W-1:0]    line_tag,
  output logic                line_valid,
  output logic                line_dirty
);

  logic [BLOCK_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;

  // Data and tags carry no reset; valid gates every use of them.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      data_mem[index] <= fill_data;
      tag_mem[index]  <= fill_tag;
    end else if (byte_we) begin
      data_mem[index][{offset, 3'b000} +: 8] <= byte_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (byte_we) begin
      dirty[index] <= 1'b1;
    end else if (clean_we) begin
      dirty[index] <= 1'b0;
    end
  end

  assign line_data  = data_mem[index];
  assign line_tag   = tag_mem[index];
  assign line_valid = valid[index];
  assign line_dirty = dirty[index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate cache between the byte CPU port and block memory.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  state_t state, next_state;
  logic entered;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;

  logic [BLOCK_W-1:0] line_data;
  logic [TAG_W-1:0]   line_tag;
  logic               line_valid;
  logic               line_dirty;

  logic hit, req, store_hit, mem_done;
  logic fill_we, clean_we;

  assign addr_tag    = address[7:5];
  assign addr_index  = address[4:2];
  assign addr_offset = address[1:0];

  assign hit       = line_valid && (line_tag == addr_tag);
  assign req       = read || write;
  // A simultaneous read and write is a load; the store is suppressed.
  assign store_hit = write && !read && hit && (state == IDLE);
  // Memory raises its stall combinationally, so the first cycle in a state never completes.
  assign mem_done  = entered && !mem_busywait;

  assign busywait = !reset && req && !((state == IDLE) && hit);
  assign readdata = hit ? line_data[{addr_offset, 3'b000} +: 8] : 8'h00;

  dcache_line_array u_lines (
    .clock      (clock),
    .reset      (reset),
    .index      (addr_index),
    .offset     (addr_offset),
    .byte_we    (store_hit),
    .byte_data  (writedata),
    .fill_we    (fill_we),
    .fill_data  (mem_readdata),
    .fill_tag   (addr_tag),
    .clean_we   (clean_we),
    .line_data  (line_data),
    .line_tag   (line_tag),
    .line_valid (line_valid),
    .line_dirty (line_dirty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      entered <= 1'b0;
    end else begin
      state   <= next_state;
      entered <= (next_state == state);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req && !hit)
          next_state = (line_valid && line_dirty) ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        // A request abandoned during write-back does not start a refill.
        if (mem_done)
          next_state = req ? REFILL : IDLE;
      end
      REFILL: begin
        if (mem_done)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 6'd0;
    mem_writedata = 32'd0;
    fill_we       = 1'b0;
    clean_we      = 1'b0;
    case (state)
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {line_tag, addr_index};
        mem_writedata = line_data;
        clean_we      = mem_done;
      end
      REFILL: begin
        mem_read    = 1'b1;
        mem_address = address[7:2];
        fill_we     = mem_done;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a latency-modelled 256-byte block memory.
module tb_dcache_controller;

  localparam int MEM_LAT = 3;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int total_checks;
  int passed_checks;

  logic [7:0] mem_model [256];
  int mem_cnt;
  int wb_seen;
  int overlap_seen;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         stall;
    logic [7:0] rdata;
    logic       chk_rd;
  } vec_t;

  vec_t tab1 [4];
  vec_t tab2 [4];

  dcache_controller dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory model: stalls MEM_LAT cycles per request, then completes on the next edge.
  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < MEM_LAT);
  assign mem_readdata = {mem_model[{mem_address, 2'd3}], mem_model[{mem_address, 2'd2}],
                         mem_model[{mem_address, 2'd1}], mem_model[{mem_address, 2'd0}]};

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_cnt <= 0;
      for (int i = 0; i < 256; i++) mem_model[i] <= 8'(i + 8'h10);
      mem_model[8'h23] <= 8'h5A;
    end else if (mem_read || mem_write) begin
      if (mem_cnt < MEM_LAT) begin
        mem_cnt <= mem_cnt + 1;
      end else begin
        mem_cnt <= 0;
        if (mem_write) begin
          mem_model[{mem_address, 2'd0}] <= mem_writedata[7:0];
          mem_model[{mem_address, 2'd1}] <= mem_writedata[15:8];
          mem_model[{mem_address, 2'd2}] <= mem_writedata[23:16];
          mem_model[{mem_address, 2'd3}] <= mem_writedata[31:24];
        end
      end
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_seen      <= 0;
      overlap_seen <= 0;
    end else begin
      if (mem_write) wb_seen <= wb_seen + 1;
      if (mem_read && mem_write) overlap_seen <= overlap_seen + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitStall(inout int stall);
    while (busywait && stall < 100) begin
      @(posedge clock);
      @(negedge clock);
      stall++;
    end
  endtask

  // Drive one CPU access at a negedge, measure the stall, check readdata, complete it.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [7:0] addr, input logic [7:0] wdata,
                               input int exp_stall, input logic [7:0] exp_rd,
                               input logic chk_rd);
    int stall;
    stall     = 0;
    read      = rd;
    write     = wr;
    address   = addr;
    writedata = wdata;
    #1;
    waitStall(stall);
    checkOutput({name, " stall"}, 32'(stall), 32'(exp_stall));
    if (chk_rd) checkOutput({name, " readdata"}, {24'd0, readdata}, {24'd0, exp_rd});
    @(posedge clock);
    #1;
    read  = 1'b0;
    write = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int stall;
    total_checks  = 0;
    passed_checks = 0;

    tab1[0] = '{rd: 1'b1, wr: 1'b0, addr: 8'h23, wdata: 8'h00, stall: 0, rdata: 8'h5A, chk_rd: 1'b1};
    tab1[1] = '{rd: 1'b0, wr: 1'b1, addr: 8'h21, wdata: 8'hC4, stall: 0, rdata: 8'h00, chk_rd: 1'b0};
    tab1[2] = '{rd: 1'b1, wr: 1'b0, addr: 8'h21, wdata: 8'h00, stall: 0, rdata: 8'hC4, chk_rd: 1'b1};
    tab1[3] = '{rd: 1'b1, wr: 1'b0, addr: 8'h20, wdata: 8'h00, stall: 0, rdata: 8'h30, chk_rd: 1'b1};

    tab2[0] = '{rd: 1'b0, wr: 1'b1, addr: 8'h4F, wdata: 8'h11, stall: 5, rdata: 8'h00, chk_rd: 1'b0};
    tab2[1] = '{rd: 1'b1, wr: 1'b0, addr: 8'h4F, wdata: 8'h00, stall: 0, rdata: 8'h11, chk_rd: 1'b1};
    tab2[2] = '{rd: 1'b1, wr: 1'b0, addr: 8'h4C, wdata: 8'h00, stall: 0, rdata: 8'h5C, chk_rd: 1'b1};
    tab2[3] = '{rd: 1'b1, wr: 1'b0, addr: 8'h0F, wdata: 8'h00, stall: 9, rdata: 8'h1F, chk_rd: 1'b1};

    reset     = 1'b1;
    read      = 1'b0;
    write     = 1'b0;
    address   = 8'h00;
    writedata = 8'h00;
    #1;
    checkOutput("reset busywait", {31'd0, busywait}, 32'd0);
    checkOutput("reset mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("reset mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("reset mem_address", {26'd0, mem_address}, 32'd0);
    checkOutput("reset mem_writedata", mem_writedata, 32'd0);
    checkOutput("reset readdata", {24'd0, readdata}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Cold read miss on a clean line.
    read    = 1'b1;
    address = 8'h23;
    #1;
    checkOutput("miss0 busywait", {31'd0, busywait}, 32'd1);
    @(negedge clock);
    checkOutput("miss0 mem_read", {31'd0, mem_read}, 32'd1);
    checkOutput("miss0 mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("miss0 mem_address", {26'd0, mem_address}, 32'h08);
    stall = 1;
    waitStall(stall);
    checkOutput("miss0 stall", 32'(stall), 32'd5);
    checkOutput("miss0 readdata", {24'd0, readdata}, 32'h5A);
    @(posedge clock);
    #1;
    read = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("tab1[%0d]", i), tab1[i].rd, tab1[i].wr, tab1[i].addr,
                    tab1[i].wdata, tab1[i].stall, tab1[i].rdata, tab1[i].chk_rd);
    checkOutput("no writeback on hits", 32'(wb_seen), 32'd0);

    // Conflict miss on dirty line 0: write-back of block 0x08, then refill of 0x20.
    read    = 1'b1;
    address = 8'h81;
    #1;
    checkOutput("evict busywait", {31'd0, busywait}, 32'd1);
    @(negedge clock);
    checkOutput("evict mem_write", {31'd0, mem_write}, 32'd1);
    checkOutput("evict mem_read low", {31'd0, mem_read}, 32'd0);
    checkOutput("evict wb address", {26'd0, mem_address}, 32'h08);
    checkOutput("evict wb data", mem_writedata, 32'h5A32C430);
    stall = 1;
    while (mem_write && stall < 100) begin
      @(negedge clock);
      stall++;
    end
    checkOutput("evict wb cycles", 32'(stall), 32'd5);
    checkOutput("evict refill mem_read", {31'd0, mem_read}, 32'd1);
    checkOutput("evict refill address", {26'd0, mem_address}, 32'h20);
    waitStall(stall);
    checkOutput("evict stall", 32'(stall), 32'd9);
    checkOutput("evict readdata", {24'd0, readdata}, 32'h91);
    @(posedge clock);
    #1;
    read = 1'b0;
    @(negedge clock);
    checkOutput("memory 0x21 written back", {24'd0, mem_model[8'h21]}, 32'hC4);

    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("tab2[%0d]", i), tab2[i].rd, tab2[i].wr, tab2[i].addr,
                    tab2[i].wdata, tab2[i].stall, tab2[i].rdata, tab2[i].chk_rd);
    checkOutput("memory 0x4F written back", {24'd0, mem_model[8'h4F]}, 32'h11);

    // read and write together act as a load: data and dirty stay untouched.
    applyStimulus("rdwr hit", 1'b1, 1'b1, 8'h0F, 8'hEE, 0, 8'h1F, 1'b1);
    applyStimulus("rdwr reread", 1'b1, 1'b0, 8'h0F, 8'h00, 0, 8'h1F, 1'b1);
    applyStimulus("rdwr clean evict", 1'b1, 1'b0, 8'h4F, 8'h00, 5, 8'h11, 1'b1);

    // Reset in the middle of a refill.
    read    = 1'b1;
    address = 8'h63;
    @(negedge clock);
    @(negedge clock);
    checkOutput("pre-reset mem_read", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("mid-reset mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("mid-reset mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("mid-reset busywait", {31'd0, busywait}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus("post-reset miss", 1'b1, 1'b0, 8'h63, 8'h00, 5, 8'h73, 1'b1);
    applyStimulus("post-reset invalid", 1'b1, 1'b0, 8'h4F, 8'h00, 5, 8'h5F, 1'b1);

    checkOutput("mem_read/mem_write overlap", 32'(overlap_seen), 32'd0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
